reg_file_scb: RTL and testbench

Parametrised multi-read-port register file with one write port, synchronous registered reads, write-first bypass and an integrated per-register busy scoreboard. It replaces the single-width, combinational-read register file in the pipelined datapath. Decode reads operands and marks destinations busy at issue; writeback writes results and clears busy. Hazard logic consumes the registered busy flags.

---
 rtl/rf_pkg.sv | 15 +
 rtl/reg_file_scb_if.sv | 39 +++
 rtl/rf_scoreboard.sv | 54 +++++
 rtl/reg_file_scb.sv | 91 +++++++++
 tb/tb_reg_file_scb.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and packed-port slice helper for the register file
// Contents:
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default register width, address width, read-port count
//   slice_off()                       : bit offset of port p inside a packed per-port bus
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

    function automatic int slice_off(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_scb_if.sv
// rtl/reg_file_scb_if.sv - read/issue/writeback bus of the register file with scoreboard
// Signals:
//   rd_en/rd_addr        : per-port read request (packed, port p at [p*ADDR_W +: ADDR_W])
//   rd_data/rd_busy      : per-port registered read data and busy flag
//   iss_en/iss_addr      : destination issue, marks register busy
//   wr_en/wr_addr/wr_data: writeback, writes data and clears busy
//   busy_vec/wr_idle_err : registered busy bits and idle-write error pulse
// Modports: master = decode/writeback side, slave = register file.
interface reg_file_scb_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) ();

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [(1<<ADDR_W)-1:0]   busy_vec;
    logic                     wr_idle_err;

    modport master (
        output rd_en, rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_busy, busy_vec, wr_idle_err
    );

    modport slave (
        input  rd_en, rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_busy, busy_vec, wr_idle_err
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy scoreboard with idle-write error flag
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   iss_en/iss_addr      : set busy on issue
//   wr_en/wr_addr        : clear busy on writeback
//   busy_vec             : registered busy bits
//   busy_nxt             : next-state busy (after this cycle's write/issue), for read ports
//   wr_idle_err          : registered pulse, last cycle wrote a register that was not busy
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    output logic [(1<<ADDR_W)-1:0] busy_vec,
    output logic [(1<<ADDR_W)-1:0] busy_nxt,
    output logic                   wr_idle_err
);

    logic wr_live;
    logic iss_live;

    // Register 0 is hard-wired when ZERO_REG is set, so it never changes state.
    assign wr_live  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
    assign iss_live = iss_en && !(ZERO_REG && (iss_addr == '0));

    // Issue is applied after the clear so a same-cycle new producer keeps the register busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_live) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (iss_live) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_vec    <= '0;
            wr_idle_err <= 1'b0;
        end else begin
            busy_vec    <= busy_nxt;
            wr_idle_err <= wr_live && !busy_vec[wr_addr];
        end
    end

endmodule

// File: rtl/reg_file_scb.sv
// rtl/reg_file_scb.sv - multi-read-port register file with write-first bypass and busy scoreboard
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : reg_file_scb_if.slave (read ports, issue, writeback, busy_vec, wr_idle_err)
module reg_file_scb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_scb_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  busy_vec;
    logic              wr_idle_err;
    logic              wr_live;

    logic [ADDR_W-1:0] ra     [NUM_RD];
    logic [DATA_W-1:0] rd_val [NUM_RD];
    logic [DATA_W-1:0] data_q [NUM_RD];
    logic [NUM_RD-1:0] busy_rd;
    logic [NUM_RD-1:0] busy_q;

    assign wr_live = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_en      (bus.iss_en),
        .iss_addr    (bus.iss_addr),
        .wr_en       (bus.wr_en),
        .wr_addr     (bus.wr_addr),
        .busy_vec    (busy_vec),
        .busy_nxt    (busy_nxt),
        .wr_idle_err (wr_idle_err)
    );

    // Per-port write-first mux: a same-cycle write to the read address is forwarded.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        assign ra[p]      = bus.rd_addr[slice_off(p, ADDR_W) +: ADDR_W];
        assign rd_val[p]  = (ZERO_REG && (ra[p] == '0))        ? '0 :
                            (wr_live && (bus.wr_addr == ra[p])) ? bus.wr_data :
                                                                  mem[ra[p]];
        assign busy_rd[p] = busy_nxt[ra[p]];
        assign bus.rd_data[slice_off(p, DATA_W) +: DATA_W] = data_q[p];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Disabled ports hold both data and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_RD; p++) begin
                data_q[p] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.rd_en[p]) begin
                    data_q[p] <= rd_val[p];
                    busy_q[p] <= busy_rd[p];
                end
            end
        end
    end

    assign bus.rd_busy     = busy_q;
    assign bus.busy_vec    = busy_vec;
    assign bus.wr_idle_err = wr_idle_err;

endmodule

// File: tb/tb_reg_file_scb.sv
// tb/tb_reg_file_scb.sv - scoreboard testbench for reg_file_scb (three parameter sets)
// Instances:
//   u_main : DATA_W=32 ADDR_W=5 NUM_RD=2 ZERO_REG=1
//   u_nz   : DATA_W=32 ADDR_W=5 NUM_RD=2 ZERO_REG=0
//   u_p4   : DATA_W=16 ADDR_W=3 NUM_RD=4 ZERO_REG=1
module tb_reg_file_scb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    reg_file_scb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) mi ();
    reg_file_scb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ni ();
    reg_file_scb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) pi ();

    reg_file_scb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) u_main (
        .clk (clk), .rst (rst), .bus (mi)
    );
    reg_file_scb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0)) u_nz (
        .clk (clk), .rst (rst), .bus (ni)
    );
    reg_file_scb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b1)) u_p4 (
        .clk (clk), .rst (rst), .bus (pi)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mi.rd_en = '0; mi.rd_addr = '0; mi.iss_en = 1'b0; mi.iss_addr = '0;
        mi.wr_en = 1'b0; mi.wr_addr = '0; mi.wr_data = '0;
        ni.rd_en = '0; ni.rd_addr = '0; ni.iss_en = 1'b0; ni.iss_addr = '0;
        ni.wr_en = 1'b0; ni.wr_addr = '0; ni.wr_data = '0;
        pi.rd_en = '0; pi.rd_addr = '0; pi.iss_en = 1'b0; pi.iss_addr = '0;
        pi.wr_en = 1'b0; pi.wr_addr = '0; pi.wr_data = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        vectors++;
        if (mi.rd_data !== '0 || mi.rd_busy !== '0 || mi.busy_vec !== '0 || mi.wr_idle_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: rd_data=%h rd_busy=%b busy_vec=%h err=%b, want all 0",
                     mi.rd_data, mi.rd_busy, mi.busy_vec, mi.wr_idle_err);
        end
        mi.wr_en = 1'b1; mi.wr_addr = 5'd5; mi.wr_data = 32'hDEADBEEF;
        mi.iss_en = 1'b1; mi.iss_addr = 5'd2;
        cyc();
        idle();
        mi.rd_en = 2'b01; mi.rd_addr = {5'd0, 5'd5};
        exp_q.push_back('{"reset_pre_r5", 0, 32'hDEADBEEF, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
        // Write in flight while reset asserts mid-cycle must be discarded.
        mi.wr_en = 1'b1; mi.wr_addr = 5'd5; mi.wr_data = 32'h0000_0001;
        rst = 1'b0;
        #1;
        vectors++;
        if (mi.rd_data !== '0 || mi.busy_vec !== '0 || mi.rd_busy !== '0) begin
            miscompares++;
            $display("FAIL reset_async: rd_data=%h busy_vec=%h rd_busy=%b, want 0",
                     mi.rd_data, mi.busy_vec, mi.rd_busy);
        end
        cyc();
        idle();
        rst = 1'b1;
        mi.rd_en = 2'b01; mi.rd_addr = {5'd0, 5'd5};
        exp_q.push_back('{"reset_post_r5", 0, 32'h0, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        idle();
        mi.wr_en = 1'b1; mi.wr_addr = 5'd7; mi.wr_data = 32'h12345678;
        mi.rd_en = 2'b11; mi.rd_addr = {5'd7, 5'd7};
        exp_q.push_back('{"bypass_p0", 0, 32'h12345678, 1'b0});
        exp_q.push_back('{"bypass_p1", 1, 32'h12345678, 1'b0});
        cyc();
        idle();
        mi.rd_en = 2'b10; mi.rd_addr = {5'd7, 5'd0};
        exp_q.push_back('{"array_r7_p1", 1, 32'h12345678, 1'b0});
        exp_q.push_back('{"bypass_p0_hold", 0, 32'h12345678, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.name == "bypass_p0" || e.name == "bypass_p1") begin
                e = e;
            end
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        idle();
        mi.wr_en = 1'b1; mi.wr_addr = 5'd0; mi.wr_data = 32'hFFFFFFFF;
        mi.iss_en = 1'b1; mi.iss_addr = 5'd0;
        mi.rd_en = 2'b01; mi.rd_addr = {5'd0, 5'd0};
        exp_q.push_back('{"zero_same_cycle", 0, 32'h0, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
        vectors++;
        if (mi.busy_vec[0] !== 1'b0 || mi.wr_idle_err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_busy: busy_vec[0]=%b err=%b, want 0 0", mi.busy_vec[0], mi.wr_idle_err);
        end
        idle();
        mi.rd_en = 2'b10; mi.rd_addr = {5'd0, 5'd0};
        exp_q.push_back('{"zero_readback", 1, 32'h0, 1'b0});
        ni.wr_en = 1'b1; ni.wr_addr = 5'd0; ni.wr_data = 32'hFFFFFFFF;
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
        vectors++;
        if (ni.wr_idle_err !== 1'b1) begin
            miscompares++;
            $display("FAIL nz_r0_idle_err: err=%b, want 1", ni.wr_idle_err);
        end
        idle();
        ni.rd_en = 2'b01; ni.rd_addr = {5'd0, 5'd0};
        cyc();
        vectors++;
        if (ni.rd_data[31:0] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL nz_r0_read: data=%h, want ffffffff", ni.rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        idle();
        mi.iss_en = 1'b1; mi.iss_addr = 5'd3;
        cyc();
        vectors++;
        if (mi.busy_vec[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_issue: busy_vec[3]=%b, want 1", mi.busy_vec[3]);
        end
        idle();
        mi.rd_en = 2'b10; mi.rd_addr = {5'd3, 5'd0};
        exp_q.push_back('{"sb_read_busy", 1, 32'h0, 1'b1});
        cyc();
        idle();
        mi.wr_en = 1'b1; mi.wr_addr = 5'd3; mi.wr_data = 32'h000000A5;
        mi.rd_en = 2'b01; mi.rd_addr = {5'd0, 5'd3};
        exp_q.push_back('{"sb_write_clear", 0, 32'h000000A5, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
        vectors++;
        if (mi.busy_vec[3] !== 1'b0 || mi.wr_idle_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_cleared: busy_vec[3]=%b err=%b, want 0 0", mi.busy_vec[3], mi.wr_idle_err);
        end
        idle();
        mi.iss_en = 1'b1; mi.iss_addr = 5'd3;
        mi.wr_en = 1'b1; mi.wr_addr = 5'd3; mi.wr_data = 32'h0000005A;
        mi.rd_en = 2'b01; mi.rd_addr = {5'd0, 5'd3};
        exp_q.push_back('{"sb_issue_wins", 0, 32'h0000005A, 1'b1});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
        // r3 was idle before this write, so the error also pulses.
        vectors++;
        if (mi.busy_vec[3] !== 1'b1 || mi.wr_idle_err !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_same_cycle: busy_vec[3]=%b err=%b, want 1 1", mi.busy_vec[3], mi.wr_idle_err);
        end
        idle();
        mi.wr_en = 1'b1; mi.wr_addr = 5'd3; mi.wr_data = 32'h0;
        cyc();
        vectors++;
        if (mi.busy_vec[3] !== 1'b0 || mi.wr_idle_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_busy_write: busy_vec[3]=%b err=%b, want 0 0", mi.busy_vec[3], mi.wr_idle_err);
        end
    endtask

    task automatic test_idle_err();
        exp_t e;
        idle();
        mi.wr_en = 1'b1; mi.wr_addr = 5'd9; mi.wr_data = 32'h99999999;
        cyc();
        vectors++;
        if (mi.wr_idle_err !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_err_pulse: err=%b, want 1", mi.wr_idle_err);
        end
        idle();
        mi.rd_en = 2'b01; mi.rd_addr = {5'd0, 5'd9};
        exp_q.push_back('{"idle_r9_read", 0, 32'h99999999, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
            end
        end
        vectors++;
        if (mi.wr_idle_err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_err_one_cycle: err=%b, want 0", mi.wr_idle_err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] model [32];
        logic [31:0] busy_m;
        logic [31:0] nb;
        logic [31:0] held  [2];
        logic        held_b[2];
        logic        we, ie, wlive, ilive, err_exp;
        logic [4:0]  wa, ia, ra;
        logic [4:0]  rsel  [2];
        logic [31:0] wd;
        logic [1:0]  ren;
        idle();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        busy_m = '0;
        for (int p = 0; p < 2; p++) begin
            held[p]   = '0;
            held_b[p] = 1'b0;
        end
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 7));
            ia = 5'($urandom_range(0, 7));
            wd = $urandom;
            ren = 2'($urandom_range(0, 3));
            rsel[0] = 5'($urandom_range(0, 7));
            rsel[1] = 5'($urandom_range(0, 7));
            mi.wr_en = we; mi.wr_addr = wa; mi.wr_data = wd;
            mi.iss_en = ie; mi.iss_addr = ia;
            mi.rd_en = ren; mi.rd_addr = {rsel[1], rsel[0]};
            wlive = we && (wa != 5'd0);
            ilive = ie && (ia != 5'd0);
            nb = busy_m;
            if (wlive) nb[wa] = 1'b0;
            if (ilive) nb[ia] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (ren[p]) begin
                    ra = rsel[p];
                    if (ra == 5'd0)               held[p] = '0;
                    else if (wlive && wa == ra)   held[p] = wd;
                    else                          held[p] = model[ra];
                    held_b[p] = nb[ra];
                end
                exp_q.push_back('{"b2b_read", p, held[p], held_b[p]});
            end
            err_exp = wlive && !busy_m[wa];
            if (wlive) model[wa] = wd;
            busy_m = nb;
            cyc();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (mi.rd_data[e.port*32 +: 32] !== e.data || mi.rd_busy[e.port] !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s n%0d p%0d: data=%h busy=%b, want data=%h busy=%b",
                             e.name, n, e.port, mi.rd_data[e.port*32 +: 32], mi.rd_busy[e.port], e.data, e.busy);
                end
            end
            vectors++;
            if (mi.busy_vec !== busy_m || mi.wr_idle_err !== err_exp) begin
                miscompares++;
                $display("FAIL b2b_state n%0d: busy_vec=%h err=%b, want busy_vec=%h err=%b",
                         n, mi.busy_vec, mi.wr_idle_err, busy_m, err_exp);
            end
        end
    endtask

    task automatic test_param();
        exp_t e;
        idle();
        for (int a = 1; a < 8; a++) begin
            pi.wr_en = 1'b1; pi.wr_addr = 3'(a); pi.wr_data = 16'(a * 16'h0111);
            cyc();
        end
        idle();
        pi.rd_en = 4'b1111; pi.rd_addr = {3'd1, 3'd1, 3'd1, 3'd1};
        for (int p = 0; p < 4; p++) exp_q.push_back('{"p4_preload", p, 32'h0111, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (pi.rd_data[e.port*16 +: 16] !== e.data[15:0] || pi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, pi.rd_data[e.port*16 +: 16], pi.rd_busy[e.port], e.data[15:0], e.busy);
            end
        end
        pi.rd_en = 4'b1011; pi.rd_addr = {3'd7, 3'd5, 3'd4, 3'd2};
        exp_q.push_back('{"p4_port0", 0, 32'h0222, 1'b0});
        exp_q.push_back('{"p4_port1", 1, 32'h0444, 1'b0});
        exp_q.push_back('{"p4_port2_hold", 2, 32'h0111, 1'b0});
        exp_q.push_back('{"p4_port3", 3, 32'h0777, 1'b0});
        cyc();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (pi.rd_data[e.port*16 +: 16] !== e.data[15:0] || pi.rd_busy[e.port] !== e.busy) begin
                miscompares++;
                $display("FAIL %s p%0d: data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.port, pi.rd_data[e.port*16 +: 16], pi.rd_busy[e.port], e.data[15:0], e.busy);
            end
        end
        vectors++;
        if (pi.busy_vec !== 8'h00) begin
            miscompares++;
            $display("FAIL p4_busy_vec: busy_vec=%h, want 00", pi.busy_vec);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_idle_err();
        test_back_to_back();
        test_param();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
